// File: rtl/circuit2_pkg.sv
// Shared types for the circuit-2 scheduler: FSM state encoding and ALU opcodes.
`default_nettype none

package circuit2_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LD_D = 3'd1,
    LD_E = 3'd2,
    LD_F = 3'd3,
    CMP  = 3'd4,
    FIN  = 3'd5,
    OUT  = 3'd6
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

`default_nettype wire

// File: rtl/circuit2_sched_addsub.sv
// Shared modulo-2^WIDTH add/subtract unit; purely combinational.
`default_nettype none

module sched_addsub
  import circuit2_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             op,
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r
);

  assign r = (op == OP_SUB) ? (p - q) : (p + q);

endmodule

`default_nettype wire

// File: rtl/circuit2_sched.sv
// Multi-cycle scheduler for the circuit-2 dataflow, time-sharing one add/sub unit
// and one comparator between valid/ready operand and result interfaces.
`default_nettype none

module circuit2_sched
  import circuit2_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] z,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic [WIDTH-1:0] d_q, d_d, e_q, e_d, f_q, f_d, g_q, g_d;
  logic             lt_q, lt_d, eq_q, eq_d;
  logic [WIDTH-1:0] x_q, x_d, z_q, z_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             alu_op;
  logic [WIDTH-1:0] alu_lhs, alu_rhs, alu_res;
  logic [WIDTH-1:0] h;

  sched_addsub #(
    .WIDTH (WIDTH)
  ) u_addsub (
    .op (alu_op),
    .p  (alu_lhs),
    .q  (alu_rhs),
    .r  (alu_res)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    d_d         = d_q;
    e_d         = e_q;
    f_d         = f_q;
    g_d         = g_q;
    lt_d        = lt_q;
    eq_d        = eq_q;
    x_d         = x_q;
    z_d         = z_q;
    out_valid_d = out_valid_q;
    cnt_d       = cnt_q;
    alu_op      = OP_ADD;
    alu_lhs     = a_q;
    alu_rhs     = b_q;
    h           = eq_q ? g_q : f_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          c_d     = c;
          state_d = LD_D;
        end
      end
      LD_D: begin
        d_d     = alu_res;
        state_d = LD_E;
      end
      LD_E: begin
        alu_rhs = c_q;
        e_d     = alu_res;
        state_d = LD_F;
      end
      LD_F: begin
        alu_op  = OP_SUB;
        f_d     = alu_res;
        state_d = CMP;
      end
      CMP: begin
        // g selects on the freshly computed flag, not the stale registered one
        lt_d    = (d_q < e_q);
        eq_d    = (d_q == e_q);
        g_d     = lt_d ? d_q : e_q;
        state_d = FIN;
      end
      FIN: begin
        x_d         = g_q << lt_q;
        z_d         = h >> eq_q;
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          cnt_d       = cnt_q + CNT_W'(1);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      d_q         <= '0;
      e_q         <= '0;
      f_q         <= '0;
      g_q         <= '0;
      lt_q        <= 1'b0;
      eq_q        <= 1'b0;
      x_q         <= '0;
      z_q         <= '0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      d_q         <= d_d;
      e_q         <= e_d;
      f_q         <= f_d;
      g_q         <= g_d;
      lt_q        <= lt_d;
      eq_q        <= eq_d;
      x_q         <= x_d;
      z_q         <= z_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign x         = x_q;
  assign z         = z_q;
  assign done_cnt  = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_circuit2_sched.sv
// Directed self-checking bench for circuit2_sched with hand-computed results.
`default_nettype none

module tb_circuit2_sched;

  localparam int WIDTH = 32;
  localparam int CNT_W = 16;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a, b, c;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] x, z;
  logic             busy;
  logic [CNT_W-1:0] done_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  circuit2_sched #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c         (c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x         (x),
    .z         (z),
    .busy      (busy),
    .done_cnt  (done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Accept a triple, scramble the inputs afterwards, then measure the latency to out_valid.
  task automatic start_and_wait(input string tag, input logic [WIDTH-1:0] ta,
                                input logic [WIDTH-1:0] tb, input logic [WIDTH-1:0] tc);
    int n;
    in_valid = 1'b1;
    a = ta; b = tb; c = tc;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom; b = $urandom; c = $urandom;
    check({tag, "_busy"}, 64'(busy), 64'd1);
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (out_valid) break;
    end
    check({tag, "_lat"}, 64'(n), 64'd5);
  endtask

  task automatic handoff(input string tag, input logic [CNT_W-1:0] exp_cnt);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_ovdrop"}, 64'(out_valid), 64'd0);
    check({tag, "_cnt"}, 64'(done_cnt), 64'(exp_cnt));
    check({tag, "_inrdy"}, 64'(in_ready), 64'd1);
  endtask

  task automatic run(input string tag, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                     input logic [WIDTH-1:0] tc, input logic [WIDTH-1:0] ex,
                     input logic [WIDTH-1:0] ez, input logic [CNT_W-1:0] exp_cnt);
    start_and_wait(tag, ta, tb, tc);
    check({tag, "_x"}, 64'(x), 64'(ex));
    check({tag, "_z"}, 64'(z), 64'(ez));
    handoff(tag, exp_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; c = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_x", 64'(x), 64'd0);
    check("rst_z", 64'(z), 64'd0);
    check("rst_ov", 64'(out_valid), 64'd0);
    check("rst_cnt", 64'(done_cnt), 64'd0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rel_inrdy", 64'(in_ready), 64'd1);
    check("rel_busy", 64'(busy), 64'd0);

    run("v1", 32'd5, 32'd3, 32'd1, 32'd6, 32'd2, 16'd1);
    run("v2", 32'd1, 32'd2, 32'd4, 32'd6, 32'hFFFF_FFFF, 16'd2);
    run("v3", 32'd2, 32'd3, 32'd3, 32'd5, 32'd2, 16'd3);
    run("v4", 32'hFFFF_FFFF, 32'd1, 32'd2, 32'd0, 32'hFFFF_FFFE, 16'd4);

    // d=14, e=30, lt=1, g=14, f=6 -> x=28, z=6; consumer stalls with in_valid asserted
    start_and_wait("bp", 32'd10, 32'd4, 32'd20);
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_ov", 64'(out_valid), 64'd1);
      check("bp_x", 64'(x), 64'd28);
      check("bp_z", 64'(z), 64'd6);
      check("bp_inrdy", 64'(in_ready), 64'd0);
    end
    check("bp_cnt_hold", 64'(done_cnt), 64'd4);
    in_valid = 1'b0;
    handoff("bp", 16'd5);

    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("idle_ordy_cnt", 64'(done_cnt), 64'd5);
    check("idle_ordy_ov", 64'(out_valid), 64'd0);

    // Reset asserted while the FSM sits in CMP
    in_valid = 1'b1;
    a = 32'd9; b = 32'd1; c = 32'd2;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("mid_busy", 64'(busy), 64'd1);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    check("mid_busy0", 64'(busy), 64'd0);
    check("mid_inrdy", 64'(in_ready), 64'd1);
    check("mid_ov", 64'(out_valid), 64'd0);
    check("mid_x", 64'(x), 64'd0);
    check("mid_z", 64'(z), 64'd0);
    check("mid_cnt", 64'(done_cnt), 64'd0);

    // d=14, e=7, lt=0, eq=0, g=7, f=0 -> x=7, z=0
    run("post", 32'd7, 32'd7, 32'd0, 32'd7, 32'd0, 16'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
